// File: rtl/rd_checker_8b10b.sv
// Per-lane 8b10b running-disparity checker with registered RD/error outputs.
// Optional saturating per-lane error counters are built when RD_ERR_CNT_EN is defined.
module rd_checker_8b10b #(
    parameter int LANES = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sym_valid,
    input  logic [10*LANES-1:0]    sym_data,
    input  logic                   clear_cnt,
    output logic [LANES-1:0]       current_rd,
    output logic [LANES-1:0]       disp_err,
    output logic [CNT_W*LANES-1:0] err_count
);

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_state_e;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [9:0] sym;
        logic [3:0] ones;
        rd_state_e  rd_q, rd_d;
        logic       err_q, err_d;

        assign sym = sym_data[10*i +: 10];

        // Symbol class comes purely from its ones count; an error still moves
        // RD to the disparity the offending symbol implies (no sticky state).
        always_comb begin
            ones = 4'd0;
            for (int b = 0; b < 10; b++) begin
                ones = ones + {3'b000, sym[b]};
            end
            rd_d  = rd_q;
            err_d = 1'b0;
            if (sym_valid) begin
                case (ones)
                    4'd5: begin
                        rd_d  = rd_q;
                        err_d = 1'b0;
                    end
                    4'd6: begin
                        rd_d  = RD_POS;
                        err_d = (rd_q == RD_POS);
                    end
                    4'd4: begin
                        rd_d  = RD_NEG;
                        err_d = (rd_q == RD_NEG);
                    end
                    default: begin
                        rd_d  = rd_q;
                        err_d = 1'b1;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q  <= RD_NEG;
                err_q <= 1'b0;
            end else begin
                rd_q  <= rd_d;
                err_q <= err_d;
            end
        end

        assign current_rd[i] = rd_q;
        assign disp_err[i]   = err_q;

`ifdef RD_ERR_CNT_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Clear beats a coincident error; the counter sticks at all-ones.
        always_comb begin
            cnt_d = cnt_q;
            if (clear_cnt) begin
                cnt_d = '0;
            end else if (err_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign err_count[CNT_W*i +: CNT_W] = cnt_q;
`endif
    end

`ifndef RD_ERR_CNT_EN
    logic unused_clear_cnt;
    assign unused_clear_cnt = clear_cnt;
    assign err_count        = '0;
`endif

endmodule

// File: doc/rd_checker_8b10b.md
RD_CHECKER_8B10B -- requirements
Module: rd_checker_8b10b

Interface
REQ-001 The module SHALL have parameter LANES, default 1, meaning the number of independent 8b10b lanes (1..8).
REQ-002 The module SHALL have parameter CNT_W, default 16, meaning the width of each per-lane error counter (2..32).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-004 The module SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 The module SHALL have port sym_valid, input, 1, meaning sym_data carries one 10-bit symbol per lane this cycle.
REQ-006 The module SHALL have port sym_data, input, 10*LANES, where lane i occupies bits [10*i+9 : 10*i].
REQ-007 The module SHALL have port clear_cnt, input, 1, a one-cycle pulse that zeroes all error counters.
REQ-008 The module SHALL have port current_rd, output, LANES, the per-lane running disparity, where 0 is RD- and 1 is RD+.
REQ-009 The module SHALL have port disp_err, output, LANES, a per-lane disparity-error pulse.
REQ-010 The module SHALL have port err_count, output, CNT_W*LANES, where lane i occupies bits [CNT_W*i+CNT_W-1 : CNT_W*i].

Function
REQ-011 Each lane SHALL hold a 2-state RD FSM (RD_NEG=0, RD_POS=1) that updates only on cycles with sym_valid=1.
REQ-012 Each lane SHALL classify its symbol by popcount: 5 ones = neutral; 6 ones = positive; 4 ones = negative; any other count = illegal.
REQ-013 Neutral symbols SHALL leave RD unchanged and SHALL not flag an error.
REQ-014 A positive symbol SHALL set RD to RD_POS, and it is legal only when RD was RD_NEG; otherwise it is an error.
REQ-015 A negative symbol SHALL set RD to RD_NEG, and it is legal only when RD was RD_POS; otherwise it is an error.
REQ-016 An illegal symbol SHALL leave RD unchanged and SHALL be an error.
REQ-017 After an error, RD SHALL resynchronise to the disparity implied by the offending symbol per REQ-014 and REQ-015, with no sticky error state.
REQ-018 current_rd and disp_err SHALL be registered, with 1-cycle latency: a symbol sampled at edge N is reflected after edge N.
REQ-019 disp_err SHALL be high for exactly one cycle per erroneous symbol, and SHALL be 0 on cycles following sym_valid=0.
REQ-020 Back-to-back valid symbols SHALL each be evaluated against the RD produced by the previous symbol, with no bubbles.
REQ-021 The per-lane counter SHALL increment by 1 on each error and SHALL saturate at 2^CNT_W-1 without wrap.
REQ-022 When clear_cnt and an error coincide, clear SHALL win and the counter becomes 0; the error pulse still appears on disp_err.
REQ-023 Lanes SHALL be fully independent: an error on one lane SHALL not affect the RD or counter of any other lane.

Reset
REQ-024 On reset=1 at a clock edge, all lanes SHALL go to current_rd=0 (RD_NEG), disp_err=0, and err_count=0.
REQ-025 Reset SHALL take priority over sym_valid and clear_cnt in the same cycle, and a symbol presented during reset SHALL be discarded.
REQ-026 Reset asserted mid-stream SHALL make the first symbol after release be evaluated against RD_NEG.

Configuration
REQ-027 With macro RD_ERR_CNT_EN defined, the error counters of REQ-021 and REQ-022 SHALL be implemented.
REQ-028 With RD_ERR_CNT_EN undefined, no counter registers SHALL exist, err_count SHALL be driven constant 0, and clear_cnt SHALL be ignored; the RD and disp_err behaviour SHALL be unchanged.

Verification
REQ-029 LANES=1, after reset: send 0x17C (6 ones), then 0x283 (4 ones) -> current_rd goes 1 then 0; disp_err stays 0.
REQ-030 LANES=1, from RD_NEG: send 0x283 (4 ones, illegal at RD-) -> disp_err=1 for one cycle, current_rd=0, err_count=1.
REQ-031 LANES=1: send 0x3FF (10 ones) -> disp_err=1, current_rd unchanged; send 0x155 (5 ones) -> no error, RD unchanged.
REQ-032 CNT_W=2: drive 5 consecutive errors -> err_count reads 1,2,3,3,3; then clear_cnt coinciding with an error -> err_count=0 and disp_err=1.
REQ-033 LANES=4: lane 2 gets two back-to-back 6-one symbols while the other lanes get legal traffic -> only disp_err[2] pulses on the second symbol; the other RDs are correct.
REQ-034 Reset asserted while in RD_POS with sym_valid=1 -> outputs are 0 the next cycle; the next 0x283 after release flags an error, since RD is RD_NEG.
